// File: rtl/space_inv_pkg.sv
// Shared types and constants for the space-invaders control blocks.
// Shot FSM encoding is exported on state_dbg, so keep values fixed.
package space_inv_pkg;

    localparam int FRAME_CNT_W = 8;

    typedef enum logic [1:0] {
        READY    = 2'd0,
        ARMED    = 2'd1,
        FLIGHT   = 2'd2,
        COOLDOWN = 2'd3
    } shot_state_t;

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchronizer plus rising-edge detect for a raw key level.
// One press pulse per low-to-high transition of the synchronized key.
module key_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic s1_q;
    logic s2_q;
    logic d_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            d_q  <= 1'b0;
        end else begin
            s1_q <= din;
            s2_q <= s1_q;
            d_q  <= s2_q;
        end
    end

    assign rise = s2_q & ~d_q;

endmodule

// File: rtl/shot_controller.sv
// Fire-request controller: debounced one-shot press, held request until
// the projectile mover acknowledges, then frame-counted cooldown.
module shot_controller
    import space_inv_pkg::*;
#(
    parameter int COOLDOWN_FRAMES    = 8,
    parameter int ACK_TIMEOUT_FRAMES = 2,
    parameter int SHOT_CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fire_key,
    input  logic                  startOfFrame,
    input  logic                  proj_active,
    output logic                  fire,
    output logic                  ready,
    output logic [SHOT_CNT_W-1:0] shots_fired,
    output logic [1:0]            state_dbg
);

    localparam int CNT_MAX = (1 << FRAME_CNT_W) - 1;

    generate
        if (COOLDOWN_FRAMES < 0 || COOLDOWN_FRAMES > CNT_MAX ||
            ACK_TIMEOUT_FRAMES < 1 || ACK_TIMEOUT_FRAMES > CNT_MAX ||
            SHOT_CNT_W < 1) begin : g_bad_param
            $error("shot_controller: parameter out of range");
        end
    endgenerate

    localparam logic [FRAME_CNT_W-1:0] CD_LIM  =
        FRAME_CNT_W'(COOLDOWN_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] ACK_LIM =
        FRAME_CNT_W'(ACK_TIMEOUT_FRAMES);

    shot_state_t             state_q;
    logic                    fire_q;
    logic [FRAME_CNT_W-1:0]  cnt_q;
    logic [FRAME_CNT_W-1:0]  cnt_d;
    logic [SHOT_CNT_W-1:0]   shots_q;
    logic                    press;
    logic                    ready_w;

    key_sync_edge u_key (
        .clk   (clk),
        .reset (reset),
        .din   (fire_key),
        .rise  (press)
    );

    assign cnt_d   = cnt_q + 1'b1;
    assign ready_w = (state_q == READY) & enable & ~proj_active & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= READY;
            fire_q  <= 1'b0;
            cnt_q   <= '0;
            shots_q <= '0;
        end else begin
            unique case (state_q)
                READY: begin
                    if (press && ready_w) begin
                        state_q <= ARMED;
                        fire_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                ARMED: begin
                    // Acknowledge takes priority over a same-cycle timeout.
                    if (proj_active) begin
                        state_q <= FLIGHT;
                        fire_q  <= 1'b0;
                        if (shots_q != '1)
                            shots_q <= shots_q + 1'b1;
                    end else if (startOfFrame) begin
                        cnt_q <= cnt_d;
                        if (cnt_d == ACK_LIM) begin
                            state_q <= READY;
                            fire_q  <= 1'b0;
                        end
                    end
                end
                FLIGHT: begin
                    if (!proj_active) begin
                        state_q <= (COOLDOWN_FRAMES == 0) ? READY : COOLDOWN;
                        cnt_q   <= '0;
                    end
                end
                COOLDOWN: begin
                    if (startOfFrame) begin
                        cnt_q <= cnt_d;
                        if (cnt_d == CD_LIM)
                            state_q <= READY;
                    end
                end
                default: state_q <= READY;
            endcase
        end
    end

    assign fire        = fire_q;
    assign ready       = ready_w;
    assign shots_fired = shots_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_shot_controller.sv
// Bench for shot_controller: per-cycle reference model plus directed
// scenarios with literal expectations.
module tb_shot_controller;

    localparam int CD   = 3;
    localparam int ACK  = 2;
    localparam int SMAX = 255;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       fire_key = 1'b0;
    logic       startOfFrame = 1'b0;
    logic       proj_active = 1'b0;
    logic       fire;
    logic       ready;
    logic [7:0] shots_fired;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit auto_sof = 1'b0;

    shot_controller #(
        .COOLDOWN_FRAMES    (CD),
        .ACK_TIMEOUT_FRAMES (ACK),
        .SHOT_CNT_W         (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .fire_key     (fire_key),
        .startOfFrame (startOfFrame),
        .proj_active  (proj_active),
        .fire         (fire),
        .ready        (ready),
        .shots_fired  (shots_fired),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference model: phase 0 waits for a press, 1 holds the request,
    // 2 waits for the projectile to end, 3 counts cooldown frames.
    int m_phase = 0;
    int m_frames = 0;
    int m_shots = 0;
    bit k1 = 0, k2 = 0, k3 = 0;
    bit m_press, m_acc;

    always @(posedge clk) begin
        m_press = k2 && !k3;
        m_acc   = (m_phase == 0) && enable && !proj_active;
        if (reset) begin
            m_phase = 0; m_frames = 0; m_shots = 0;
            k1 = 0; k2 = 0; k3 = 0;
        end else begin
            case (m_phase)
                0: if (m_press && m_acc) begin
                    m_phase = 1; m_frames = 0;
                end
                1: if (proj_active) begin
                    m_phase = 2;
                    if (m_shots < SMAX) m_shots++;
                end else if (startOfFrame) begin
                    m_frames++;
                    if (m_frames >= ACK) m_phase = 0;
                end
                2: if (!proj_active) begin
                    m_phase = (CD == 0) ? 0 : 3; m_frames = 0;
                end
                default: if (startOfFrame) begin
                    m_frames++;
                    if (m_frames >= CD) m_phase = 0;
                end
            endcase
            k3 = k2; k2 = k1; k1 = fire_key;
        end
        #1;
        chk("m_fire", int'(fire), int'(m_phase == 1));
        chk("m_ready", int'(ready),
            int'(m_phase == 0 && enable && !proj_active && !reset));
        chk("m_shots", int'(shots_fired), m_shots);
        chk("m_state", int'(state_dbg), m_phase);
    end

    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
        if (auto_sof) startOfFrame = (cyc % 8 == 0);
    endtask

    task automatic key_on();
        fire_key = 1'b1;
        repeat (3) tick();
    endtask

    task automatic key_off();
        fire_key = 1'b0;
        repeat (3) tick();
    endtask

    task automatic sof_pulse();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    int hi;
    int rises;
    bit prev;

    initial begin
        repeat (2) tick();
        chk("rst_fire", int'(fire), 0);
        chk("rst_ready", int'(ready), 0);
        chk("rst_state", int'(state_dbg), 0);
        chk("rst_shots", int'(shots_fired), 0);
        reset = 1'b0;
        enable = 1'b1;
        tick();
        chk("idle_ready", int'(ready), 1);

        // No acknowledge: request abandoned on the 2nd frame
        key_on();
        chk("to_fire_up", int'(fire), 1);
        chk("to_state", int'(state_dbg), 1);
        key_off();
        sof_pulse();
        chk("to_fire_f1", int'(fire), 1);
        sof_pulse();
        chk("to_fire_drop", int'(fire), 0);
        chk("to_state_rdy", int'(state_dbg), 0);
        chk("to_shots", int'(shots_fired), 0);

        // Single press, acknowledged 5 cycles after fire rises
        fire_key = 1'b1;
        tick();
        tick();
        chk("lat_early", int'(fire), 0);
        tick();
        chk("lat_fire", int'(fire), 1);
        chk("lat_armed", int'(state_dbg), 1);
        fire_key = 1'b0;
        hi = 1;
        repeat (5) begin
            tick();
            if (fire) hi++;
        end
        proj_active = 1'b1;
        tick();
        chk("ack_fire", int'(fire), 0);
        chk("ack_state", int'(state_dbg), 2);
        chk("ack_shots", int'(shots_fired), 1);
        chk("fire_len", hi, 6);
        proj_active = 1'b0;
        tick();
        chk("cd_state", int'(state_dbg), 3);

        // Cooldown: presses after 1st/2nd frame and on the 3rd are dropped
        sof_pulse();
        key_on();
        chk("cd1_fire", int'(fire), 0);
        key_off();
        sof_pulse();
        key_on();
        chk("cd2_fire", int'(fire), 0);
        key_off();
        fire_key = 1'b1;
        tick();
        tick();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        chk("cd3_state", int'(state_dbg), 0);
        chk("cd3_fire", int'(fire), 0);
        tick();
        chk("cd3_held", int'(fire), 0);
        key_off();
        key_on();
        chk("cd_accept", int'(fire), 1);
        proj_active = 1'b1;
        tick();
        proj_active = 1'b0;
        tick();
        key_off();
        repeat (3) sof_pulse();
        chk("shots_two", int'(shots_fired), 2);

        // Key held for 20 frames: one request only
        key_on();
        rises = fire ? 1 : 0;
        prev = fire;
        auto_sof = 1'b1;
        repeat (160) begin
            tick();
            if (fire && !prev) rises++;
            prev = fire;
        end
        auto_sof = 1'b0;
        startOfFrame = 1'b0;
        chk("hold_rises", rises, 1);
        key_off();

        // Disabled: press ignored
        enable = 1'b0;
        tick();
        chk("dis_ready", int'(ready), 0);
        key_on();
        chk("dis_fire", int'(fire), 0);
        key_off();
        enable = 1'b1;
        tick();

        // Reset while armed
        key_on();
        chk("ra_fire", int'(fire), 1);
        reset = 1'b1;
        fire_key = 1'b0;
        tick();
        chk("ra_fire0", int'(fire), 0);
        chk("ra_state", int'(state_dbg), 0);
        chk("ra_ready", int'(ready), 0);
        chk("ra_shots", int'(shots_fired), 0);
        reset = 1'b0;
        repeat (3) tick();

        // Saturation after 256 acknowledged shots
        for (int i = 0; i < 256; i++) begin
            key_on();
            proj_active = 1'b1;
            tick();
            proj_active = 1'b0;
            tick();
            fire_key = 1'b0;
            repeat (3) sof_pulse();
            if (i == 9) chk("shots_ten", int'(shots_fired), 10);
        end
        chk("shots_sat", int'(shots_fired), 255);

        tick();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/shot_controller.md
# shot_controller

Fire-request controller sitting directly upstream of the projectile mover. It turns the raw, asynchronous fire key into a clean, rate-limited fire request, and holds that request until the projectile mover acknowledges it by raising `active`. It then tracks the shot in flight and enforces a frame-counted cooldown before the next shot may be requested. There is one shot per key press, no queuing and no auto-repeat.

## Interface
Parameters:
- `COOLDOWN_FRAMES`, 8: startOfFrame pulses to wait after the projectile deactivates. 0 means no cooldown.
- `ACK_TIMEOUT_FRAMES`, 2: startOfFrame pulses to wait in ARMED for `proj_active` before abandoning the request. Minimum 1.
- `SHOT_CNT_W`, 8: width of the shot counter.

Ports (clock and reset first):
- `clk`, in, 1: system clock. The block uses one clock.
- `reset`, in, 1: synchronous, active-high reset.
- `enable`, in, 1: gates acceptance of new presses only. In-progress shots complete regardless.
- `fire_key`, in, 1: raw keyboard level, asynchronous to `clk`.
- `startOfFrame`, in, 1: one-cycle pulse per frame.
- `proj_active`, in, 1: `active` output of the projectile mover.
- `fire`, out, 1: fire request to the projectile mover. It is a level, not a pulse.
- `ready`, out, 1: asserted when a press would be accepted this cycle.
- `shots_fired`, out, `SHOT_CNT_W`: count of acknowledged shots, saturating.
- `state_dbg`, out, 2: current FSM state encoding.

## Operation
Input conditioning:
- Two-flop synchronizer on `fire_key`, producing `key_s2`.
- One delay flop, producing `key_d`.
- `press` = `key_s2` & ~`key_d`.

FSM states: READY=0, ARMED=1, FLIGHT=2, COOLDOWN=3.
- READY:
  - `ready` = `enable` & ~`proj_active`.
  - If `press` & `ready`: go to ARMED, set `fire`=1, clear the frame counter.
  - A press seen while `ready`=0 is dropped.
- ARMED:
  - `fire` is held at 1.
  - If `proj_active`=1: go to FLIGHT, set `fire`=0, increment `shots_fired` (saturating at all-ones).
  - Otherwise, each startOfFrame increments the frame counter. When the counter reaches `ACK_TIMEOUT_FRAMES`: set `fire`=0 and go to READY. `shots_fired` does not change.
  - If `proj_active` and the final startOfFrame arrive in the same cycle, the acknowledge wins.
- FLIGHT:
  - Wait for `proj_active`=0, then go to COOLDOWN and clear the frame counter.
  - If `COOLDOWN_FRAMES`=0, go to READY instead.
- COOLDOWN:
  - Each startOfFrame increments the counter. When it reaches `COOLDOWN_FRAMES`, go to READY.
  - A press in the same cycle as expiry is dropped, because `ready` is still 0.

Further rules:
- Presses arriving outside READY are never stored.
- The frame counter is 8 bits wide. Parameters above 255 are illegal and must be caught by an elaboration assertion.

## Timing
- Reset values: `fire`=0, `ready`=0 during reset, `shots_fired`=0, state=READY, all sync/edge flops=0, counter=0.
- Reset mid-operation (any state) returns all registers to their reset values on the same edge. A dropped `fire` is permitted.
- Press latency:
  - `fire_key` first sampled high at edge N.
  - `press` is high between edges N+1 and N+2.
  - `fire`=1 after edge N+2.
- Acknowledge: `fire` falls on the edge after the first cycle with `proj_active`=1 while ARMED. The `shots_fired` update is registered on that same edge.
- `fire` is held for at least one full frame, so the mover samples it in MOVE_ST regardless of its own phase.
- A key held high produces exactly one press. Releasing and pressing again is required for the next shot.

## Structure
- Shared package `space_inv_pkg`:
  - enum `shot_state_t` (2-bit, encodings as above), matching `state_dbg`.
  - localparam `FRAME_CNT_W`=8.
- Sub-module `key_sync_edge`:
  - synchronizer plus rising-edge detect.
  - ports `clk`, `reset`, `din`, `rise`.
  - reusable for other keys.
- Top level: FSM, frame counter, shot counter.

## Test plan
- Single press, mover acknowledges 5 cycles after `fire` rises. Expect:
  - `fire` high for exactly 6 cycles.
  - `shots_fired` goes 0→1.
  - state sequence READY→ARMED→FLIGHT.
- Mover never acknowledges, `ACK_TIMEOUT_FRAMES`=2. Expect:
  - `fire` drops on the edge after the 2nd startOfFrame.
  - state returns to READY.
  - `shots_fired` stays 0.
- Cooldown, with `COOLDOWN_FRAMES`=3:
  - Press pulses at 1 and 2 startOfFrame after `proj_active` falls are ignored.
  - A press after the 3rd startOfFrame is accepted.
  - A press in the same cycle as the 3rd startOfFrame is dropped.
- Key held high for 20 frames → exactly one `fire` request. With `enable`=0 and a press → no `fire`, `ready`=0.
- `reset` asserted while ARMED → `fire`=0 and state=READY on the next edge. 256 acknowledged shots with `SHOT_CNT_W`=8 → `shots_fired` saturates at 255.
